// File: rtl/cfg_pwm_timer.sv
// ============================================================================
//  Module   : cfg_pwm_timer
//  Purpose  : Prescaled 16-bit two-channel PWM timer driven by a flat config
//             register bank, with shadowed period/duty and a status byte.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cfg_pwm_timer #(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [NUM_REGS*WIDTH-1:0] config_regs,
    output logic [1:0]                pwm_out,
    output logic [WIDTH-1:0]          status_regs
);

    logic [3:0]       r_ctrl_q;
    logic [7:0]       r_pre;
    logic [15:0]      r_cnt;
    logic [15:0]      r_per;
    logic [15:0]      r_duty [2];
    logic             r_running;
    logic             r_wrap;
    logic             r_done;
    logic [1:0]       r_pwm;
    logic [WIDTH-1:0] r_status;

    logic [3:0]       w_ctrl;
    logic [7:0]       w_prescale;
    logic [15:0]      w_period;
    logic [15:0]      w_duty_cfg [2];
    logic             w_en_rise;
    logic             w_clr_rise;
    logic             w_unused_cfg;

    logic [7:0]       w_pre_n;
    logic [15:0]      w_cnt_n;
    logic [15:0]      w_per_n;
    logic [15:0]      w_duty_n [2];
    logic             w_running_n;
    logic             w_wrap_set;
    logic             w_done_set;
    logic             w_wrap_n;
    logic             w_done_n;
    logic [1:0]       w_raw;

    assign w_ctrl        = config_regs[3:0];
    assign w_prescale    = config_regs[15:8];
    assign w_period      = config_regs[31:16];
    assign w_duty_cfg[0] = config_regs[47:32];
    assign w_duty_cfg[1] = config_regs[63:48];
    assign w_unused_cfg  = ^config_regs;

    assign w_en_rise  = w_ctrl[0] & ~r_ctrl_q[0];
    assign w_clr_rise = w_ctrl[3] & ~r_ctrl_q[3];

    always_comb begin
        w_pre_n     = r_pre;
        w_cnt_n     = r_cnt;
        w_per_n     = r_per;
        w_duty_n[0] = r_duty[0];
        w_duty_n[1] = r_duty[1];
        w_running_n = r_running;
        w_wrap_set  = 1'b0;
        w_done_set  = 1'b0;

        if (w_en_rise) begin
            w_per_n     = w_period;
            w_duty_n[0] = w_duty_cfg[0];
            w_duty_n[1] = w_duty_cfg[1];
            w_cnt_n     = '0;
            w_pre_n     = '0;
            w_running_n = 1'b1;
        end else if (!w_ctrl[0]) begin
            w_running_n = 1'b0;
            w_cnt_n     = '0;
            w_pre_n     = '0;
        end else if (r_running) begin
            if (r_pre == w_prescale) begin
                w_pre_n = '0;
                if (r_cnt == r_per) begin
                    // Shadows reload only at the period boundary so a running period never glitches.
                    w_cnt_n     = '0;
                    w_per_n     = w_period;
                    w_duty_n[0] = w_duty_cfg[0];
                    w_duty_n[1] = w_duty_cfg[1];
                    w_wrap_set  = 1'b1;
                    if (w_ctrl[1]) begin
                        w_running_n = 1'b0;
                        w_done_set  = 1'b1;
                    end
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end else begin
                w_pre_n = r_pre + 8'd1;
            end
        end

        w_wrap_n = w_wrap_set | (r_wrap & ~w_clr_rise);
        w_done_n = w_done_set | (r_done & ~w_clr_rise & ~w_en_rise);

        for (int i = 0; i < 2; i++) begin
            w_raw[i] = r_running && (r_cnt < r_duty[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl_q  <= '0;
            r_pre     <= '0;
            r_cnt     <= '0;
            r_per     <= '0;
            r_duty[0] <= '0;
            r_duty[1] <= '0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
            r_done    <= 1'b0;
            r_pwm     <= '0;
            r_status  <= '0;
        end else if (ena) begin
            r_ctrl_q  <= w_ctrl;
            r_pre     <= w_pre_n;
            r_cnt     <= w_cnt_n;
            r_per     <= w_per_n;
            r_duty[0] <= w_duty_n[0];
            r_duty[1] <= w_duty_n[1];
            r_running <= w_running_n;
            r_wrap    <= w_wrap_n;
            r_done    <= w_done_n;
            r_pwm     <= w_raw ^ {2{w_ctrl[2]}};
            r_status  <= {{(WIDTH-4){1'b0}}, w_ctrl[0], w_done_n, w_wrap_n, w_running_n};
        end
    end

    assign pwm_out     = r_pwm;
    assign status_regs = r_status;

endmodule

`default_nettype wire

// File: tb/tb_cfg_pwm_timer.sv
// ============================================================================
//  Module   : tb_cfg_pwm_timer
//  Purpose  : Directed self-checking bench for cfg_pwm_timer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cfg_pwm_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [63:0] cfg;
    logic [1:0]  pwm_out;
    logic [7:0]  status_regs;

    int n_chk  = 0;
    int n_pass = 0;

    cfg_pwm_timer #(.NUM_REGS(8), .WIDTH(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .config_regs (cfg),
        .pwm_out     (pwm_out),
        .status_regs (status_regs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int n, input logic [7:0] v);
        cfg[8*n +: 8] = v;
    endtask

    task automatic setup(input logic [7:0] p, input logic [15:0] per,
                         input logic [15:0] d0, input logic [15:0] d1);
        set_reg(1, p);
        cfg[31:16] = per;
        cfg[47:32] = d0;
        cfg[63:48] = d1;
    endtask

    // Disable the timer while pulsing CLR so sticky flags start clean.
    task automatic stop_and_clear();
        set_reg(0, 8'h08);
        tick();
        set_reg(0, 8'h00);
        tick();
    endtask

    logic [19:0] vec0, vec1;
    logic        wrap_early;
    logic [1:0]  frz_pwm;
    logic [7:0]  frz_stat;
    int          changes;
    int          total;

    initial begin
        rst = 1'b1;
        ena = 1'b1;
        cfg = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_pwm", {30'd0, pwm_out}, 32'h0);
        chk("reset_status", {24'd0, status_regs}, 32'h0);

        // Basic PWM: p=0, P=9, DUTY0=3, DUTY1=10.
        setup(8'd0, 16'd9, 16'd3, 16'd10);
        tick();
        set_reg(0, 8'h01);
        tick();
        chk("t1_start_status", {24'd0, status_regs}, 32'h09);
        vec0 = '0; vec1 = '0; wrap_early = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            vec0[k] = pwm_out[0];
            vec1[k] = pwm_out[1];
            if (k == 8) wrap_early = status_regs[1];
        end
        chk("t1_pwm0_pattern", {22'd0, vec0[9:0]}, 32'h007);
        chk("t1_pwm1_const", {22'd0, vec1[9:0]}, 32'h3FF);
        chk("t1_wrap_before", {31'd0, wrap_early}, 32'h0);
        chk("t1_wrap_status", {24'd0, status_regs}, 32'h0B);

        // Duty change mid-period takes effect only at the next period.
        vec0 = '0;
        for (int k = 0; k < 20; k++) begin
            tick();
            vec0[k] = pwm_out[0];
            if (k == 4) cfg[47:32] = 16'd7;
        end
        chk("t2_shadow_pwm0", {12'd0, vec0}, {12'd0, 10'b0001111111, 10'b0000000111});

        // Prescaler p=3, P=4, DUTY0=0, DUTY1=2, INVERT.
        stop_and_clear();
        setup(8'd3, 16'd4, 16'd0, 16'd2);
        set_reg(0, 8'h05);
        tick();
        chk("t3_start_status", {24'd0, status_regs}, 32'h09);
        vec0 = '0; vec1 = '0; wrap_early = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            vec0[k] = pwm_out[0];
            vec1[k] = pwm_out[1];
            if (k == 18) wrap_early = status_regs[1];
        end
        chk("t3_pwm0_inv_const", {12'd0, vec0}, 32'hFFFFF);
        chk("t3_pwm1_prescaled", {12'd0, vec1}, 32'hFFF00);
        chk("t3_wrap_before_20", {31'd0, wrap_early}, 32'h0);
        chk("t3_wrap_at_20", {24'd0, status_regs}, 32'h0B);

        // One-shot: P=5, DUTY0=2.
        stop_and_clear();
        setup(8'd0, 16'd5, 16'd2, 16'd0);
        set_reg(0, 8'h03);
        tick();
        vec0 = '0;
        for (int k = 0; k < 7; k++) begin
            tick();
            vec0[k] = pwm_out[0];
        end
        chk("t4_oneshot_pulse", {25'd0, vec0[6:0]}, 32'h03);
        chk("t4_done_status", {24'd0, status_regs}, 32'h0E);
        for (int k = 0; k < 5; k++) tick();
        chk("t4_no_restart_pwm", {30'd0, pwm_out}, 32'h0);
        chk("t4_no_restart_status", {24'd0, status_regs}, 32'h0E);
        set_reg(0, 8'h0B);
        tick();
        chk("t4_clr_status", {24'd0, status_regs}, 32'h08);

        // Freeze with ena=0 at cnt=4, P=9.
        stop_and_clear();
        setup(8'd0, 16'd9, 16'd3, 16'd5);
        set_reg(0, 8'h01);
        tick();
        for (int k = 0; k < 4; k++) tick();
        frz_pwm  = pwm_out;
        frz_stat = status_regs;
        chk("t5_pwm_at_cnt4", {30'd0, frz_pwm}, 32'h2);
        ena = 1'b0;
        changes = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (pwm_out !== frz_pwm || status_regs !== frz_stat) changes++;
        end
        chk("t5_frozen", changes, 32'd0);
        ena = 1'b1;
        total = 11;
        for (int k = 0; k < 30; k++) begin
            tick();
            total++;
            if (status_regs[1]) break;
        end
        chk("t5_period_len", total, 32'd17);

        // Reset mid-run with EN still high.
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_pwm", {30'd0, pwm_out}, 32'h0);
        chk("t6_rst_status", {24'd0, status_regs}, 32'h0);
        tick();
        chk("t6_restart_status", {24'd0, status_regs}, 32'h09);
        tick();
        chk("t6_restart_pwm_cnt0", {30'd0, pwm_out}, 32'h3);

        // EN low forces raw PWM low and clears RUNNING.
        set_reg(0, 8'h00);
        tick();
        chk("t7_disable_status", {24'd0, status_regs}, 32'h00);
        tick();
        chk("t7_disable_pwm", {30'd0, pwm_out}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
